// File: rtl/fb_pkg.sv
// Shared frame-buffer constants: geometry defaults, capture scales, window limits, steps.
// Also imported by the frame-buffer reader so both sides agree on the capture geometry.
package fb_pkg;

    localparam int FB_W_DEF = 240;
    localparam int FB_H_DEF = 320;
    localparam int FB_DEPTH = 76800;
    localparam int ADDR_W   = 17;

    typedef enum logic [1:0] {
        SCALE_1_1     = 2'b00,
        SCALE_1_2     = 2'b01,
        SCALE_3_8     = 2'b10,
        SCALE_3_8_ALT = 2'b11
    } scale_e;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        CAPTURE  = 1'b1
    } fb_state_e;

    localparam logic [10:0] H_LIM_1_1 = 11'd240;
    localparam logic [10:0] H_LIM_1_2 = 11'd480;
    localparam logic [10:0] H_LIM_3_8 = 11'd640;

    localparam logic [9:0] V_LIM_1_1 = 10'd320;
    localparam logic [9:0] V_LIM_1_2 = 10'd640;
    localparam logic [9:0] V_LIM_3_8 = 10'd853;

    localparam logic [3:0] STEP_1_1 = 4'd8;
    localparam logic [3:0] STEP_1_2 = 4'd4;
    localparam logic [3:0] STEP_3_8 = 4'd3;

    function automatic logic [10:0] h_limit(scale_e s);
        case (s)
            SCALE_1_1: h_limit = H_LIM_1_1;
            SCALE_1_2: h_limit = H_LIM_1_2;
            default:   h_limit = H_LIM_3_8;
        endcase
    endfunction

    function automatic logic [9:0] v_limit(scale_e s);
        case (s)
            SCALE_1_1: v_limit = V_LIM_1_1;
            SCALE_1_2: v_limit = V_LIM_1_2;
            default:   v_limit = V_LIM_3_8;
        endcase
    endfunction

    function automatic logic [3:0] step_of(scale_e s);
        case (s)
            SCALE_1_1: step_of = STEP_1_1;
            SCALE_1_2: step_of = STEP_1_2;
            default:   step_of = STEP_3_8;
        endcase
    endfunction

endpackage

// File: rtl/fb_writer_decim_acc.sv
// 3-bit phase accumulator deciding which indices survive decimation by step/8.
// clear restarts the phase at 0 in the same cycle, so the clearing index is always kept.
module decim_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] step,
    input  logic       advance,
    input  logic       clear,
    output logic       keep
);

    logic [2:0] acc_q;
    logic [2:0] phase;

    assign phase = clear ? 3'd0 : acc_q;
    assign keep  = {1'b0, phase} < step;

    // step 8 wraps to +0 mod 8, so scale 1:1 keeps every index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 3'd0;
        end else if (advance) begin
            acc_q <= phase + step[2:0];
        end else if (clear) begin
            acc_q <= 3'd0;
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Decimating camera-to-frame-buffer writer with 1:1, 1:2 and 3:8 capture scales.
// Define FB_WRITER_PIXEL_SWAP_EN to byte-swap each RGB565 pixel on its way to the buffer.
module fb_writer
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEF,
    parameter int FB_H = FB_H_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [1:0]  scale_in,
    input  logic        cam_valid_in,
    input  logic [15:0] cam_pixel_in,
    input  logic [10:0] cam_hcount_in,
    input  logic [9:0]  cam_vcount_in,
    output logic [16:0] bram_addr_out,
    output logic [15:0] bram_data_out,
    output logic        bram_we_out,
    output logic        frame_done_out,
    output logic [1:0]  scale_active_out
);

    localparam logic [10:0] X_LIM     = 11'(FB_W);
    localparam logic [9:0]  Y_LIM     = 10'(FB_H);
    localparam logic [16:0] ROW_STEP  = 17'(FB_W);
    localparam logic [16:0] LAST_ADDR = 17'(FB_W * FB_H - 1);

    fb_state_e   state_q, state_d;
    scale_e      scale_q, scale_eff;
    logic [10:0] x_q, x_cur, x_next;
    logic [9:0]  y_q, y_cur;
    logic [16:0] base_q, base_cur;
    logic        row_keep_q, row_kept;
    logic        sof, active, in_win, row_start;
    logic        col_keep, row_keep;
    logic [3:0]  step;
    logic [16:0] addr_d;
    logic [15:0] data_d;
    logic        we_d, last;

    assign sof       = cam_valid_in && cam_hcount_in == 11'd0
                       && cam_vcount_in == 10'd0;
    assign active    = cam_valid_in && (state_q == CAPTURE || sof);
    assign scale_eff = sof ? scale_e'(scale_in) : scale_q;
    assign step      = step_of(scale_eff);
    assign in_win    = cam_hcount_in < h_limit(scale_eff)
                       && cam_vcount_in < v_limit(scale_eff);
    assign row_start = active && cam_hcount_in == 11'd0;

    decim_acc u_col_acc (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .step    (step),
        .advance (active && in_win),
        .clear   (row_start),
        .keep    (col_keep)
    );

    decim_acc u_row_acc (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .step    (step),
        .advance (row_start),
        .clear   (sof),
        .keep    (row_keep)
    );

`ifdef FB_WRITER_PIXEL_SWAP_EN
    assign data_d = {cam_pixel_in[7:0], cam_pixel_in[15:8]};
`else
    assign data_d = cam_pixel_in;
`endif

    always_comb begin
        state_d  = state_q;
        x_cur    = x_q;
        y_cur    = y_q;
        base_cur = base_q;
        row_kept = row_keep_q;
        if (row_start) begin
            x_cur    = 11'd0;
            row_kept = row_keep;
            if (sof) begin
                y_cur    = 10'd0;
                base_cur = 17'd0;
            end else if (row_keep_q && y_q < Y_LIM) begin
                // the row just finished was kept: move to the next buffer line
                y_cur    = y_q + 10'd1;
                base_cur = base_q + ROW_STEP;
            end
        end
        x_next = (in_win && col_keep && x_cur < X_LIM) ? x_cur + 11'd1 : x_cur;
        addr_d = base_cur + 17'(x_cur);
        we_d   = active && in_win && row_kept && col_keep
                 && x_cur < X_LIM && y_cur < Y_LIM;
        last   = we_d && addr_d == LAST_ADDR;
        if (last) begin
            state_d = WAIT_SOF;
        end else if (sof) begin
            state_d = CAPTURE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q        <= 11'd0;
            y_q        <= 10'd0;
            base_q     <= 17'd0;
            row_keep_q <= 1'b0;
        end else if (active) begin
            x_q <= x_next;
            if (row_start) begin
                y_q        <= y_cur;
                base_q     <= base_cur;
                row_keep_q <= row_keep;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_we_out      <= 1'b0;
            bram_addr_out    <= 17'd0;
            bram_data_out    <= 16'd0;
            frame_done_out   <= 1'b0;
            scale_active_out <= 2'b00;
        end else begin
            bram_we_out    <= we_d;
            frame_done_out <= last;
            if (we_d) begin
                bram_addr_out <= addr_d;
                bram_data_out <= data_d;
            end
            if (sof) begin
                scale_active_out <= scale_eff;
            end
        end
    end

    assign scale_q = scale_e'(scale_active_out);

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: a closed-form decimation model predicts every write.
// Runs with a short buffer (240x16) so whole frames fit a small cycle budget.
module tb_fb_writer;

    localparam int W = 240;
    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  scale = 2'b00;
    logic        cam_valid = 1'b0;
    logic [15:0] cam_pixel = 16'd0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic [16:0] bram_addr;
    logic [15:0] bram_data;
    logic        bram_we;
    logic        frame_done;
    logic [1:0]  scale_active;

    fb_writer #(.FB_W(W), .FB_H(H)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .scale_in         (scale),
        .cam_valid_in     (cam_valid),
        .cam_pixel_in     (cam_pixel),
        .cam_hcount_in    (hcount),
        .cam_vcount_in    (vcount),
        .bram_addr_out    (bram_addr),
        .bram_data_out    (bram_data),
        .bram_we_out      (bram_we),
        .frame_done_out   (frame_done),
        .scale_active_out (scale_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
        logic        done;
    } wr_t;

    wr_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    logic m_on = 1'b0;
    logic [1:0] m_sc = 2'b00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [15:0] p);
`ifdef FB_WRITER_PIXEL_SWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    function automatic int step_of(input logic [1:0] s);
        return s == 2'b00 ? 8 : s == 2'b01 ? 4 : 3;
    endfunction

    function automatic int hlim(input logic [1:0] s);
        return s == 2'b00 ? 240 : s == 2'b01 ? 480 : 640;
    endfunction

    function automatic int vlim(input logic [1:0] s);
        return s == 2'b00 ? 320 : s == 2'b01 ? 640 : 853;
    endfunction

    // kept indices before i: multiples of 8 in [0,(i-1)*s]
    function automatic int kept_before(input int i, input int s);
        return i == 0 ? 0 : ((i - 1) * s) / 8 + 1;
    endfunction

    task automatic pix(input logic v, input int h, input int vc,
                       input logic [15:0] p);
        int s, x, y, a;
        wr_t e;
        @(negedge clk);
        cam_valid = v;
        hcount    = 11'(h);
        vcount    = 10'(vc);
        cam_pixel = p;
        if (v) begin
            if (h == 0 && vc == 0) begin
                m_on = 1'b1;
                m_sc = scale;
            end
            s = step_of(m_sc);
            if (m_on && h < hlim(m_sc) && vc < vlim(m_sc)
                && (h * s) % 8 < s && (vc * s) % 8 < s) begin
                x = kept_before(h, s);
                y = kept_before(vc, s);
                if (x < W && y < H) begin
                    a      = y * W + x;
                    e.addr = 17'(a);
                    e.data = exp_data(p);
                    e.done = (a == W * H - 1);
                    sb.push_back(e);
                    if (e.done) m_on = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_maybe();
        if ($urandom_range(15) == 0)
            pix(1'b0, $urandom_range(1) == 0 ? 0 : $urandom_range(2047),
                $urandom_range(1) == 0 ? 0 : $urandom_range(1023),
                16'($urandom));
    endtask

    task automatic send_rows(input int cols, input int v0, input int v1,
                             input int h0);
        for (int v = v0; v < v1; v++) begin
            for (int h = (v == v0 ? h0 : 0); h < cols; h++) begin
                idle_maybe();
                pix(1'b1, h, v, 16'($urandom));
            end
        end
    endtask

    task automatic flush();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, 32'(bram_we), 0);
        check({tag, "_addr"}, 32'(bram_addr), 0);
        check({tag, "_data"}, 32'(bram_data), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_scale"}, 32'(scale_active), 0);
    endtask

    task automatic full_frame(input logic [1:0] sc, input int cols,
                              input int rows, input string tag);
        int w0, d0;
        w0    = wr_cnt;
        d0    = done_cnt;
        scale = sc;
        send_rows(cols, 0, rows, 0);
        flush();
        check({tag, "_writes"}, 32'(wr_cnt - w0), W * H);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
        check({tag, "_sb_left"}, 32'(sb.size()), 0);
        check({tag, "_scale"}, 32'(scale_active), 32'(sc));
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bram_we) begin
                wr_cnt++;
                if (frame_done) done_cnt++;
                check("write_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("addr", 32'(bram_addr), 32'(e.addr));
                    check("data", 32'(bram_data), 32'(e.data));
                    check("done", 32'(frame_done), 32'(e.done));
                end
            end else begin
                check("done_idle", 32'(frame_done), 0);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        full_frame(2'b00, 240, 17, "s00");
        full_frame(2'b01, 640, 33, "s01");
        full_frame(2'b10, 640, 42, "s10");

        // scale change mid-frame must not take effect until the next SOF
        scale = 2'b01;
        send_rows(640, 0, 2, 0);
        scale = 2'b00;
        send_rows(640, 2, 4, 0);
        #1;
        check("scale_hold", 32'(scale_active), 32'(2'b01));
        pix(1'b1, 0, 0, 16'hABCD);
        @(posedge clk);
        #1;
        check("scale_new", 32'(scale_active), 32'(2'b00));
`ifdef FB_WRITER_PIXEL_SWAP_EN
        check("swap_abcd", 32'(bram_data), 32'h0000CDAB);
`else
        check("swap_abcd", 32'(bram_data), 32'h0000ABCD);
`endif
        send_rows(240, 0, 10, 1);
        send_rows(240, 10, 11, 0);
        flush();

        // asynchronous reset in the middle of a frame
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        m_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_rows(240, 11, 14, 0);
        flush();
        check("post_reset_sb", 32'(sb.size()), 0);
        check("post_reset_we", 32'(bram_we), 0);
        scale = 2'b00;
        pix(1'b1, 0, 0, 16'h1234);
        @(posedge clk);
        #1;
        check("sof_we", 32'(bram_we), 1);
        check("sof_addr", 32'(bram_addr), 0);
        send_rows(240, 0, 3, 1);
        flush();
        check("final_sb", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
